// File: rtl/jtag_boundary_scan_chain.sv
// Boundary-scan register chain (capture/shift stage + update/hold stage) with functional/test pin mux.
// Capture/shift/update take effect one tck edge later; pin_out mux is combinational; no backpressure.
module jtag_boundary_scan_chain #(
    parameter int           N        = 8,
    parameter logic [N-1:0] SAFE_VAL = '0,
    parameter int           CW       = 8
) (
    input  logic          tck,
    input  logic          trst,
    input  logic          bsr_clk,
    input  logic          bsr_shift,
    input  logic          bsr_update,
    input  logic          bsr_mode,
    input  logic          bsr_tdi,
    output logic          bsr_tdo,
    input  logic [N-1:0]  pin_in,
    output logic [N-1:0]  pin_out,
    output logic [CW-1:0] shift_cnt
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [N-1:0]  sreg;
    logic [N-1:0]  ureg;
    logic [CW-1:0] cnt;

    // Shift/capture stage and its bit counter
    always_ff @(posedge tck) begin
        if (trst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (bsr_clk) begin
            if (bsr_shift) begin
                sreg <= {bsr_tdi, sreg[N-1:1]};
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                sreg <= pin_in;
                cnt  <= '0;
            end
        end
    end

    // Non-blocking read of sreg gives the pre-edge value on a same-edge shift/capture
    always_ff @(posedge tck) begin
        if (trst) begin
            ureg <= SAFE_VAL;
        end else if (bsr_update) begin
            ureg <= sreg;
        end
    end

    always_comb begin
        pin_out = bsr_mode ? ureg : pin_in;
    end

    assign bsr_tdo   = sreg[0];
    assign shift_cnt = cnt;

endmodule

// File: tb/tb_jtag_boundary_scan_chain.sv
// Scoreboard bench for jtag_boundary_scan_chain (N=8, SAFE_VAL=8'hA5, CW=4).
module tb_jtag_boundary_scan_chain;

    localparam int          N    = 8;
    localparam int          CW   = 4;
    localparam logic [7:0]  SAFE = 8'hA5;

    logic          tck = 1'b0;
    logic          trst;
    logic          bsr_clk;
    logic          bsr_shift;
    logic          bsr_update;
    logic          bsr_mode;
    logic          bsr_tdi;
    logic          bsr_tdo;
    logic [N-1:0]  pin_in;
    logic [N-1:0]  pin_out;
    logic [CW-1:0] shift_cnt;

    jtag_boundary_scan_chain #(.N(N), .SAFE_VAL(SAFE), .CW(CW)) dut (
        .tck        (tck),
        .trst       (trst),
        .bsr_clk    (bsr_clk),
        .bsr_shift  (bsr_shift),
        .bsr_update (bsr_update),
        .bsr_mode   (bsr_mode),
        .bsr_tdi    (bsr_tdi),
        .bsr_tdo    (bsr_tdo),
        .pin_in     (pin_in),
        .pin_out    (pin_out),
        .shift_cnt  (shift_cnt)
    );

    always #5 tck = ~tck;

    localparam int SIG_TDO = 0;
    localparam int SIG_CNT = 1;
    localparam int SIG_PIN = 2;

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // reference model state for the random phase
    logic [7:0] m_s;
    logic [7:0] m_u;
    logic [3:0] m_c;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sig, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                SIG_TDO: chk(e.tag, {7'b0, bsr_tdo}, e.val);
                SIG_CNT: chk(e.tag, {4'b0, shift_cnt}, e.val);
                default: chk(e.tag, pin_out, e.val);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
        drain();
    endtask

    task automatic ctl(input logic c, input logic s, input logic u, input logic d);
        bsr_clk    = c;
        bsr_shift  = s;
        bsr_update = u;
        bsr_tdi    = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] ns;
        logic [7:0] nu;
        logic [3:0] nc;

        // Reset with test mode on
        trst = 1'b1; bsr_mode = 1'b1; pin_in = 8'h00;
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        push("rst_pin_out", SIG_PIN, SAFE);
        push("rst_tdo", SIG_TDO, 8'h00);
        push("rst_cnt", SIG_CNT, 8'h00);
        tick();
        bsr_mode = 1'b0; pin_in = 8'h3C; #1;
        push("rst_func_pin_out", SIG_PIN, 8'h3C);
        drain();
        trst = 1'b0;

        // Capture C3 then scan it out
        pin_in = 8'hC3;
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        v = 8'hC3;
        ctl(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push($sformatf("scanout_tdo[%0d]", i), SIG_TDO, {7'b0, v[i]});
            drain();
            tick();
        end
        push("scanout_cnt", SIG_CNT, 8'd8);
        push("scanout_tdo_end", SIG_TDO, 8'h00);
        drain();
        bsr_mode = 1'b1;
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        push("scanout_sreg_zero", SIG_PIN, 8'h00);
        tick();

        // Scan in 5A LSB first; counter runs 8 -> saturates at 15
        v = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            ctl(1'b1, 1'b1, 1'b0, v[i]);
            tick();
        end
        push("scanin_cnt_sat", SIG_CNT, 8'd15);
        push("scanin_pre_update", SIG_PIN, 8'h00);
        drain();
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        push("scanin_update", SIG_PIN, 8'h5A);
        tick();
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        pin_in = 8'hE7; bsr_mode = 1'b0; #1;
        push("mode_off_same_cycle", SIG_PIN, 8'hE7);
        drain();
        bsr_mode = 1'b1; #1;
        push("mode_on_same_cycle", SIG_PIN, 8'h5A);
        drain();

        // Same-edge shift + update from sreg=F0
        pin_in = 8'hF0;
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        ctl(1'b1, 1'b1, 1'b1, 1'b1);
        push("shupd_ureg_old", SIG_PIN, 8'hF0);
        push("shupd_tdo", SIG_TDO, 8'h00);
        push("shupd_cnt", SIG_CNT, 8'd1);
        tick();
        // Same-edge capture + update: ureg gets F8, sreg gets 11
        pin_in = 8'h11;
        ctl(1'b1, 1'b0, 1'b1, 1'b0);
        push("capupd_ureg_old", SIG_PIN, 8'hF8);
        push("capupd_tdo", SIG_TDO, 8'h01);
        push("capupd_cnt", SIG_CNT, 8'd0);
        tick();
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        push("capupd_sreg", SIG_PIN, 8'h11);
        tick();

        // Counter saturation over 20 shifts, then capture clears it
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 20; i++) begin
            ctl(1'b1, 1'b1, 1'b0, 1'b0);
            push($sformatf("sat_cnt[%0d]", i), SIG_CNT, (i > 15) ? 8'd15 : 8'(i));
            tick();
        end
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        push("hold_cnt", SIG_CNT, 8'd15);
        tick();
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        push("sat_capture_clr", SIG_CNT, 8'd0);
        tick();

        // Reset mid-shift
        pin_in = 8'hFF;
        ctl(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            ctl(1'b1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        trst = 1'b1;
        ctl(1'b1, 1'b1, 1'b1, 1'b1);
        push("midrst_tdo", SIG_TDO, 8'h00);
        push("midrst_cnt", SIG_CNT, 8'h00);
        push("midrst_ureg", SIG_PIN, SAFE);
        tick();
        trst = 1'b0;
        pin_in = 8'h81;
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        push("postrst_cap_tdo", SIG_TDO, 8'h01);
        push("postrst_cap_pin", SIG_PIN, SAFE);
        tick();
        ctl(1'b1, 1'b1, 1'b0, 1'b0);
        push("postrst_shift_tdo", SIG_TDO, 8'h00);
        push("postrst_shift_cnt", SIG_CNT, 8'd1);
        tick();

        // Random phase against a reference model, starting from reset
        trst = 1'b1;
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        m_s = 8'h00; m_u = SAFE; m_c = 4'd0;
        for (int i = 0; i < 120; i++) begin
            trst       = ($urandom_range(0, 15) == 0);
            bsr_clk    = $urandom_range(0, 3) != 0;
            bsr_shift  = $urandom_range(0, 3) != 0;
            bsr_update = $urandom_range(0, 4) == 0;
            bsr_tdi    = $urandom_range(0, 1) == 1;
            bsr_mode   = $urandom_range(0, 1) == 1;
            pin_in     = 8'($urandom);
            ns = m_s; nu = m_u; nc = m_c;
            if (trst) begin
                ns = 8'h00; nu = SAFE; nc = 4'd0;
            end else begin
                if (bsr_update) nu = m_s;
                if (bsr_clk) begin
                    if (bsr_shift) begin
                        ns = {bsr_tdi, m_s[7:1]};
                        if (m_c != 4'hF) nc = m_c + 4'd1;
                    end else begin
                        ns = pin_in;
                        nc = 4'd0;
                    end
                end
            end
            m_s = ns; m_u = nu; m_c = nc;
            push($sformatf("rnd_tdo[%0d]", i), SIG_TDO, {7'b0, m_s[0]});
            push($sformatf("rnd_cnt[%0d]", i), SIG_CNT, {4'b0, m_c});
            push($sformatf("rnd_pin[%0d]", i), SIG_PIN, bsr_mode ? m_u : pin_in);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_boundary_scan_chain.md
# jtag_boundary_scan_chain

Parameterised boundary-scan register (BSR) chain that sits directly downstream of `tt_um_jtag_test_logic`. It consumes that block's `bsr_tdi`, `bsr_clk`, `bsr_shift`, `bsr_update` and `bsr_mode` controls. It returns `bsr_tdo` to close the scan loop. It also muxes N functional pin values between core-driven data and test-driven update data.

## Interface
Parameters:
- `N`, 8: number of boundary cells; legal range 2..64.
- `SAFE_VAL`, all zeros (N bits): reset value of the update register.
- `CW`, 8: width of `shift_cnt`.

Ports:
- `tck`  in  1: sole clock; all state updates on rising edge.
- `trst`  in  1: synchronous, active-high reset.
- `bsr_clk`  in  1: cell enable, sampled each `tck`. No action when low.
- `bsr_shift`  in  1: with `bsr_clk` high, 1 = shift and 0 = capture.
- `bsr_update`  in  1: single-cycle strobe; transfers the shift register to the update register.
- `bsr_mode`  in  1: 1 = test mode (`pin_out` driven from the update register); 0 = functional mode.
- `bsr_tdi`  in  1: serial scan input.
- `bsr_tdo`  out  1: serial scan output, equal to `sreg[0]`.
- `pin_in`  in  N: core/pad values to be observed.
- `pin_out`  out  N: muxed pin values.
- `shift_cnt`  out  CW: number of bits shifted since the last capture; saturates.

## Operation
- State:
  - `sreg[N-1:0]`: shift/capture stage.
  - `ureg[N-1:0]`: update/hold stage.
  - `cnt[CW-1:0]`: shift counter.
- Capture (`bsr_clk`=1, `bsr_shift`=0): `sreg <= pin_in`, `cnt <= 0`.
- Shift (`bsr_clk`=1, `bsr_shift`=1):
  - `sreg <= {bsr_tdi, sreg[N-1:1]}`.
  - Bit 0 leaves first through `bsr_tdo`; `bsr_tdi` enters at bit N-1.
  - `cnt <= cnt+1`, saturating at 2^CW-1 with no wrap.
- Hold (`bsr_clk`=0): `sreg` and `cnt` are unchanged.
- Update (`bsr_update`=1): `ureg <= sreg`, using the value of `sreg` before any same-edge shift or capture.
- `bsr_update` is independent of `bsr_clk`.
- `ureg` changes only on update or reset.
- Output mux (combinational): `pin_out = bsr_mode ? ureg : pin_in`.
- `bsr_mode` toggles take effect in the same cycle.
- `bsr_tdo = sreg[0]` is a register output; no combinational path from `bsr_tdi`.
- `shift_cnt = cnt`.
- Simultaneous events:
  - Shift + update on the same edge: `ureg` gets the old `sreg`; `sreg` shifts.
  - Capture + update on the same edge: `ureg` gets the old `sreg`; `sreg` gets `pin_in`.
- Reset mid-operation: `trst` overrides everything on that edge. Partial shift data is discarded.

## Timing
- Reset values:
  - `sreg` = 0, so `bsr_tdo` = 0.
  - `ureg` = `SAFE_VAL`.
  - `cnt` = 0, so `shift_cnt` = 0.
  - `pin_out` = `SAFE_VAL` if `bsr_mode`=1, else `pin_in`.
- Capture latency: `pin_in` sampled at edge k is visible on `bsr_tdo` (bit 0) after edge k.
- Shift latency: a bit presented on `bsr_tdi` at edge k appears on `bsr_tdo` after edge k+N-1. A full N-bit scan-out needs N shift cycles after capture.
- Update latency: `pin_out` reflects new `ureg` one edge after the `bsr_update` sample (when `bsr_mode`=1).
- `bsr_update` held high for multiple cycles re-copies `sreg` every cycle; this is legal.
- No handshake: controls are trusted from the upstream TAP, one operation per `tck` edge.

## Test plan
- Reset: assert `trst` with `bsr_mode`=1, N=8, `SAFE_VAL`=8'hA5 -> `pin_out`=8'hA5, `bsr_tdo`=0, `shift_cnt`=0.
- Capture + scan-out: `pin_in`=8'hC3, one capture, then 8 shifts with `bsr_tdi`=0 -> `bsr_tdo` sequence (before each shift edge) 1,1,0,0,0,0,1,1; `shift_cnt`=8; `sreg`=0.
- Scan-in + update: shift in 8'h5A LSB-first, pulse `bsr_update`, `bsr_mode`=1 -> `pin_out`=8'h5A. Set `bsr_mode`=0 -> `pin_out` follows `pin_in` in the same cycle.
- Same-edge shift + update: `sreg`=8'hF0, `bsr_tdi`=1, `bsr_clk`=`bsr_shift`=`bsr_update`=1 -> `ureg`=8'hF0, `sreg`=8'hF8.
- Counter saturation: `CW`=4, 20 consecutive shifts -> `shift_cnt` stops at 15. A following capture -> `shift_cnt`=0.
- Reset mid-shift: after 3 of 8 shifts, assert `trst` for one edge -> `sreg`=0, `cnt`=0, `ureg`=`SAFE_VAL`. A subsequent capture works normally.
